// File: rtl/rect_mover_if.sv
// rtl/rect_mover_if.sv - control/pixel bundle between a rect_mover and its host
interface rect_mover_if;
  logic       go;
  logic [7:0] in_x;
  logic [6:0] in_y;
  logic [2:0] colour;
  logic       dir;
  logic       pause;
  logic [7:0] out_x;
  logic [6:0] out_y;
  logic [2:0] out_colour;
  logic       plot;
  logic       busy;
  logic       at_edge;

  modport slave (
    input  go, in_x, in_y, colour, dir, pause,
    output out_x, out_y, out_colour, plot, busy, at_edge
  );

  modport master (
    output go, in_x, in_y, colour, dir, pause,
    input  out_x, out_y, out_colour, plot, busy, at_edge
  );
endinterface

// File: rtl/rect_mover.sv
// rtl/rect_mover.sv - draws a rectangle, waits, erases and moves it vertically; RECT_MOVER_WRAP_EN wraps at screen limits
module rect_mover #(
  parameter int RECT_W          = 40,
  parameter int RECT_H          = 10,
  parameter int TICKS_PER_FRAME = 833333,
  parameter int FRAMES_PER_STEP = 15,
  parameter int STEP            = 1,
  parameter int Y_MAX           = 120,
  parameter int X_MAX           = 160
) (
  input  logic        clock,
  input  logic        reset_n,
  rect_mover_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRAW  = 3'd1,
    S_WAIT  = 3'd2,
    S_ERASE = 3'd3,
    S_MOVE  = 3'd4
  } state_t;

  localparam int TW = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
  localparam int FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [TW-1:0] TICK_LOAD  = TW'(TICKS_PER_FRAME - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_STEP - 1);
  localparam logic [7:0]    QX_LAST    = 8'(RECT_W - 1);
  localparam logic [6:0]    QY_LAST    = 7'(RECT_H - 1);
  localparam logic [7:0]    STEP_W     = 8'(STEP);
  localparam logic [7:0]    Y_LIM      = 8'(Y_MAX - RECT_H);

  state_t          state_q, state_d;
  logic [7:0]      x_q, x_d;
  logic [6:0]      y_q, y_d;
  logic [2:0]      col_q, col_d;
  logic [7:0]      qx_q, qx_d;
  logic [6:0]      qy_q, qy_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic            at_edge_q, at_edge_d;
  logic            last_px;
  logic [7:0]      y_ext;

  // State and datapath registers; reset abandons any pass in flight
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      col_q     <= '0;
      qx_q      <= '0;
      qy_q      <= '0;
      tick_q    <= '0;
      frame_q   <= '0;
      at_edge_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      col_q     <= col_d;
      qx_q      <= qx_d;
      qy_q      <= qy_d;
      tick_q    <= tick_d;
      frame_q   <= frame_d;
      at_edge_q <= at_edge_d;
    end
  end

  // Next-state logic: scan passes, frame timing and the vertical move
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    col_d     = col_q;
    qx_d      = qx_q;
    qy_d      = qy_q;
    tick_d    = tick_q;
    frame_d   = frame_q;
`ifdef RECT_MOVER_WRAP_EN
    // A wrap is only flagged for one cycle; motion carries on
    at_edge_d = 1'b0;
`else
    at_edge_d = at_edge_q;
`endif
    last_px   = (qx_q == QX_LAST) && (qy_q == QY_LAST);
    y_ext     = {1'b0, y_q};

    case (state_q)
      S_IDLE: begin
        if (bus.go) begin
          x_d       = bus.in_x;
          y_d       = bus.in_y;
          col_d     = bus.colour;
          qx_d      = '0;
          qy_d      = '0;
          at_edge_d = 1'b0;
          state_d   = S_DRAW;
        end
      end
      S_DRAW, S_ERASE: begin
        if (last_px) begin
          qx_d = '0;
          qy_d = '0;
          if (state_q == S_ERASE) begin
            state_d = S_MOVE;
          end else begin
`ifdef RECT_MOVER_WRAP_EN
            state_d = S_WAIT;
`else
            // A clamped move leaves the rectangle parked at the limit
            state_d = at_edge_q ? S_IDLE : S_WAIT;
`endif
            tick_d  = TICK_LOAD;
            frame_d = '0;
          end
        end else if (qx_q == QX_LAST) begin
          qx_d = '0;
          qy_d = qy_q + 7'd1;
        end else begin
          qx_d = qx_q + 8'd1;
        end
      end
      S_WAIT: begin
        if (!bus.pause) begin
          if (tick_q == '0) begin
            if (frame_q == FRAME_LAST) begin
              frame_d = '0;
              state_d = S_ERASE;
            end else begin
              tick_d  = TICK_LOAD;
              frame_d = frame_q + 1'b1;
            end
          end else begin
            tick_d = tick_q - 1'b1;
          end
        end
      end
      S_MOVE: begin
        if (!bus.dir) begin
          if (y_ext >= STEP_W) begin
            y_d = 7'(y_ext - STEP_W);
          end else begin
            at_edge_d = 1'b1;
`ifdef RECT_MOVER_WRAP_EN
            y_d = 7'(Y_LIM);
`endif
          end
        end else begin
          if ((y_ext + STEP_W) <= Y_LIM) begin
            y_d = 7'(y_ext + STEP_W);
          end else begin
            at_edge_d = 1'b1;
`ifdef RECT_MOVER_WRAP_EN
            y_d = '0;
`endif
          end
        end
        state_d = S_DRAW;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.out_x      = x_q + qx_q;
  assign bus.out_y      = y_q + qy_q;
  assign bus.out_colour = (state_q == S_DRAW) ? col_q : 3'b000;
  assign bus.plot       = (state_q == S_DRAW) || (state_q == S_ERASE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.at_edge    = at_edge_q;

endmodule
